lsu_mem_stage: RTL

Memory-access stage directly downstream of the ALU.
- Consumes the ALU result as the effective address (loads/stores) or as the pass-through result (all other instructions).
- Drives a single-port data-memory request/grant/response bus.
- Presents a registered, aligned, sign/zero-extended writeback value to the writeback stage under a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_mem_stage_if.sv | 47 ++++
 rtl/lsu_load_align.sv | 40 ++++
 rtl/lsu_mem_stage.sv | 125 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
//------------------------------------------------------------------------------
// Module : lsu_pkg
// Brief  : Shared size encodings, FSM state type and alignment helper for the
//          load/store memory stage.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Size encoding 3 is treated as a word, same as SZ_W.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    if (size == SZ_B) begin
      return 1'b0;
    end else if (size == SZ_H) begin
      return addr_lo[0];
    end else begin
      return (addr_lo != 2'b00);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_stage_if.sv
//------------------------------------------------------------------------------
// Module : lsu_mem_stage_if
// Brief  : Upstream, data-memory and writeback signals of the memory stage.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lsu_mem_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            in_is_load;
  logic            in_is_store;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_res;
  logic [XLEN-1:0] in_rs2;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            out_exc;

  // The stage masters the memory bus; the environment is the slave side.
  modport master (
    input  in_valid, in_is_load, in_is_store, in_funct3, in_alu_res, in_rs2,
    input  mem_gnt, mem_rvalid, mem_rdata, out_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output out_valid, out_data, out_exc
  );

  modport slave (
    output in_valid, in_is_load, in_is_store, in_funct3, in_alu_res, in_rs2,
    output mem_gnt, mem_rvalid, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  out_valid, out_data, out_exc
  );
endinterface

`default_nettype wire

// File: rtl/lsu_load_align.sv
//------------------------------------------------------------------------------
// Module : lsu_load_align
// Brief  : Combinational load lane select with sign/zero extension.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sext;

  always_comb begin
    case (addr_lo_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    w_sext = ~funct3_i[2];

    case (funct3_i[1:0])
      SZ_B:    data_o = {{24{w_sext & w_byte[7]}}, w_byte};
      SZ_H:    data_o = {{16{w_sext & w_half[15]}}, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_stage.sv
//------------------------------------------------------------------------------
// Module : lsu_mem_stage
// Brief  : Memory-access stage: issues loads/stores on a req/gnt/rvalid bus and
//          returns an aligned, extended writeback value under valid/ready.
//          Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_stage_if.master bus
);

  state_e          state_q, state_d;
  logic            is_load_q, is_store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, rs2_q, out_data_q;
  logic            out_exc_q;
  logic            w_is_ls;
  logic            w_trap;
  logic [XLEN-1:0] w_load_data;

  assign w_is_ls = bus.in_is_load | bus.in_is_store;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = w_is_ls & lsu_misaligned(bus.in_funct3[1:0], bus.in_alu_res[1:0]);
`else
  // Low address bits below the access size are simply dropped downstream.
  assign w_trap = 1'b0;
`endif

  lsu_load_align u_load_align (
    .rdata_i   (bus.mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .data_o    (w_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = (w_is_ls && !w_trap) ? REQ : DONE;
      REQ:  if (bus.mem_gnt) state_d = is_store_q ? DONE : WAIT;
      WAIT: if (bus.mem_rvalid) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.mem_req   = (state_q == REQ);
    bus.out_valid = (state_q == DONE);
    bus.mem_we    = is_store_q;
    bus.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    bus.mem_be    = 4'h0;
    bus.mem_wdata = '0;
    if (is_store_q) begin
      case (funct3_q[1:0])
        SZ_B: begin
          bus.mem_be    = 4'b0001 << addr_q[1:0];
          bus.mem_wdata = {4{rs2_q[7:0]}};
        end
        SZ_H: begin
          bus.mem_be    = 4'b0011 << {addr_q[1], 1'b0};
          bus.mem_wdata = {2{rs2_q[15:0]}};
        end
        default: begin
          bus.mem_be    = 4'hF;
          bus.mem_wdata = rs2_q;
        end
      endcase
    end else if (is_load_q) begin
      bus.mem_be = 4'hF;
    end
    bus.out_data = out_data_q;
    bus.out_exc  = out_exc_q;
  end

  // out_data_q preloads the ALU result: final for pass-through and traps,
  // overwritten later for memory accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      rs2_q      <= '0;
      out_data_q <= '0;
      out_exc_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          is_load_q  <= bus.in_is_load;
          is_store_q <= bus.in_is_store;
          funct3_q   <= bus.in_funct3;
          addr_q     <= bus.in_alu_res;
          rs2_q      <= bus.in_rs2;
          out_data_q <= bus.in_alu_res;
          out_exc_q  <= w_trap;
        end
        REQ:  if (bus.mem_gnt && is_store_q) out_data_q <= '0;
        WAIT: if (bus.mem_rvalid) out_data_q <= w_load_data;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
